// File: rtl/seq_mult_32bit_pkg.sv
// rtl/seq_mult_32bit_pkg.sv - shared constants and state encoding for the shift-add multiplier
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_mult_32bit_if.sv
// rtl/seq_mult_32bit_if.sv - start/busy/done bus of the multiplier; is_signed exists with SEQ_MULT_SIGNED_EN
interface seq_mult_32bit_if #(
  parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
`ifdef SEQ_MULT_SIGNED_EN
  logic             is_signed;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

`ifdef SEQ_MULT_SIGNED_EN
  modport master (output start, multiplicand, multiplier, is_signed,
                  input  busy, done, product_hi, product_lo);
  modport slave  (input  start, multiplicand, multiplier, is_signed,
                  output busy, done, product_hi, product_lo);
`else
  modport master (output start, multiplicand, multiplier,
                  input  busy, done, product_hi, product_lo);
  modport slave  (input  start, multiplicand, multiplier,
                  output busy, done, product_hi, product_lo);
`endif

endinterface

// File: rtl/seq_mult_32bit_control.sv
// rtl/seq_mult_32bit_control.sv - IDLE/RUN/DONE sequencer and bit counter of the multiplier
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  output logic o_busy,
  output logic o_done,
  output logic o_load,
  output logic o_shift_en,
  output logic o_last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy     = (r_state == RUN) || (r_state == DONE);
  assign o_done     = (r_state == DONE);
  assign o_load     = (r_state == IDLE) && i_start;
  assign o_shift_en = (r_state == RUN);
  assign o_last     = (r_state == RUN) && (r_cnt == LAST_CNT);

endmodule

// File: rtl/seq_mult_32bit.sv
// rtl/seq_mult_32bit.sv - shift-add multiplier datapath, one multiplier bit per cycle
// Optional signed mode: SEQ_MULT_SIGNED_EN
module seq_mult_32bit
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_mult_32bit_if.slave      bus
);

  logic w_busy, w_done, w_load, w_shift_en, w_last;

  mult_control #(.WIDTH(WIDTH)) u_control (
    .clk        (clk),
    .reset      (reset),
    .i_start    (bus.start),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_load     (w_load),
    .o_shift_en (w_shift_en),
    .o_last     (w_last)
  );

  logic [WIDTH-1:0]   r_m, r_q, r_acc, r_hi, r_lo;
  logic               r_neg;
  logic [WIDTH-1:0]   w_m_in, w_q_in;
  logic               w_neg_in;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_acc_nx, w_q_nx;
  logic [2*WIDTH-1:0] w_prod, w_result;

`ifdef SEQ_MULT_SIGNED_EN
  logic w_m_neg, w_q_neg;
  assign w_m_neg  = bus.is_signed & bus.multiplicand[WIDTH-1];
  assign w_q_neg  = bus.is_signed & bus.multiplier[WIDTH-1];
  assign w_m_in   = w_m_neg ? (~bus.multiplicand + WIDTH'(1)) : bus.multiplicand;
  assign w_q_in   = w_q_neg ? (~bus.multiplier + WIDTH'(1)) : bus.multiplier;
  assign w_neg_in = w_m_neg ^ w_q_neg;
`else
  assign w_m_in   = bus.multiplicand;
  assign w_q_in   = bus.multiplier;
  assign w_neg_in = 1'b0;
`endif

  // Carry out of the add becomes the new acc MSB; sum[0] shifts into Q.
  assign w_sum    = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
  assign w_acc_nx = w_sum[WIDTH:1];
  assign w_q_nx   = {w_sum[0], r_q[WIDTH-1:1]};
  assign w_prod   = {w_acc_nx, w_q_nx};
  assign w_result = r_neg ? (~w_prod + (2*WIDTH)'(1)) : w_prod;

  // Product is captured on the final shift so it is already valid while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m   <= '0;
      r_q   <= '0;
      r_acc <= '0;
      r_neg <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_load) begin
        r_m   <= w_m_in;
        r_q   <= w_q_in;
        r_acc <= '0;
        r_neg <= w_neg_in;
      end else if (w_shift_en) begin
        r_acc <= w_acc_nx;
        r_q   <= w_q_nx;
      end
      if (w_last) {r_hi, r_lo} <= w_result;
    end
  end

  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.product_hi = r_hi;
  assign bus.product_lo = r_lo;

endmodule

// File: tb/tb_seq_mult_32bit.sv
// tb/tb_seq_mult_32bit.sv - scoreboard bench for seq_mult_32bit; signed cases with SEQ_MULT_SIGNED_EN
module tb_seq_mult_32bit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic [63:0] prod;
    int          t0;
  } exp_t;
  exp_t sb[$];

  seq_mult_32bit_if #(.WIDTH(32)) bus ();

  seq_mult_32bit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (prev_done) chk("done_width", {63'd0, bus.done}, 64'd0);
    prev_done = bus.done;
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("product_hi", {32'd0, bus.product_hi}, {32'd0, e.prod[63:32]});
        chk("product_lo", {32'd0, bus.product_lo}, {32'd0, e.prod[31:0]});
        chk("latency", 64'(cyc - e.t0), 64'd33);
      end
    end
  end

  function automatic logic [63:0] model(input logic [31:0] m, input logic [31:0] q, input bit sgn);
    logic [63:0] mx, qx;
    mx = sgn ? {{32{m[31]}}, m} : {32'd0, m};
    qx = sgn ? {{32{q[31]}}, q} : {32'd0, q};
    return mx * qx;
  endfunction

  // Called at a negedge with the DUT idle; returns one negedge after the accepting edge.
  task automatic go(input logic [31:0] m, input logic [31:0] q, input bit sgn, input bit push);
    bus.multiplicand = m;
    bus.multiplier   = q;
`ifdef SEQ_MULT_SIGNED_EN
    bus.is_signed    = sgn;
`endif
    bus.start = 1'b1;
    if (push) sb.push_back('{model(m, q, sgn), cyc});
    @(negedge clk);
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
`ifdef SEQ_MULT_SIGNED_EN
    bus.is_signed    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_hi", {32'd0, bus.product_hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.product_lo}, 64'd0);

    go(32'd3, 32'd5, 1'b0, 1'b1);
    chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
    wait_empty();

    go(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    wait_empty();

    go(32'd7, 32'd9, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    bus.multiplicand = 32'd2;
    bus.multiplier   = 32'd2;
    bus.start        = 1'b1;
    chk("hold_hi", {32'd0, bus.product_hi}, 64'hFFFFFFFE);
    chk("hold_lo", {32'd0, bus.product_lo}, 64'h00000001);
    @(negedge clk);
    bus.start = 1'b0;
    wait_empty();

    go(32'd5, 32'd6, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    chk("abort_hi", {32'd0, bus.product_hi}, 64'd0);
    chk("abort_lo", {32'd0, bus.product_lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    go(32'd4, 32'd4, 1'b0, 1'b1);
    wait_empty();

    bus.multiplicand = 32'd2;
    bus.multiplier   = 32'd3;
    bus.start        = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{64'd6, cyc});
      repeat (34) @(negedge clk);
    end
    bus.multiplicand = 32'd0;
    bus.multiplier   = 32'd0;
    sb.push_back('{64'd0, cyc});
    @(negedge clk);
    bus.start = 1'b0;
    wait_empty();

    for (int k = 0; k < 4; k++) begin
      go($urandom, $urandom, 1'b0, 1'b1);
      wait_empty();
    end

`ifdef SEQ_MULT_SIGNED_EN
    go(32'hFFFFFFFD, 32'd7, 1'b1, 1'b1);
    wait_empty();
    go(32'hFFFFFFFD, 32'd7, 1'b0, 1'b1);
    wait_empty();
    go(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);
    wait_empty();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
